lcd_scanout: RTL
================

// Module: lcd_scanout
// PURPOSE
//  Downstream consumer of the LCD framebuffer RAM. Streams the whole framebuffer, one byte per
//  write strobe, to an 8080-style 8-bit parallel LCD. Each frame starts with a RAM-write command,
//  then continuous refresh. Drives the RAM read address and consumes its 1-cycle-latency read data.
// PARAMETERS
//  FB_SIZE      153600  bytes per frame (320x240 RGB565); equals fbsize of the framebuffer RAM
//  WR_LOW_CYC   2       cycles lcd_wr_n held low per byte (>=1)
//  WR_HIGH_CYC  2       cycles lcd_wr_n held high per byte (>=1)
//  GAP_CYC      16      idle cycles between frames, cs_n high (>=1)
//  CMD_RAMWR    8'h2C   command byte sent at start of each frame
// PORTS
//  clk       in   1   system clock, all logic on rising edge
//  reset     in   1   asynchronous, active-high reset
//  enable    in   1   1 = run continuous refresh; sampled only in IDLE
//  rad       out  32  framebuffer read address (registered)
//  rdata     in   8   framebuffer read data, valid 1 cycle after rad
//  lcd_cs_n  out  1   LCD chip select, active low
//  lcd_dc    out  1   0 = command byte, 1 = pixel data byte
//  lcd_wr_n  out  1   write strobe; LCD latches lcd_data on rising edge
//  lcd_data  out  8   LCD parallel data (registered)
//  busy      out  1   1 whenever state != IDLE
//  frame_done out 1   1-cycle pulse after last byte of a frame
// BEHAVIOUR
//  Reset (async, immediate, also mid-frame): state=IDLE, rad=0, lcd_cs_n=1, lcd_dc=1,
//   lcd_wr_n=1, lcd_data=0, busy=0, frame_done=0, byte/phase counters=0. No partial frame resumes.
//  All outputs are registers; nothing combinational reaches the pins.
//  States: IDLE -> CMD -> DATA -> GAP -> IDLE.
//  Byte slot: WR_LOW_CYC cycles wr_n=0 then WR_HIGH_CYC cycles wr_n=1; lcd_data/lcd_dc
//   stable across the whole slot. Slot length S = WR_LOW_CYC+WR_HIGH_CYC.
//  IDLE: rad=0, cs_n=1. Edge with enable=1: -> CMD; same edge cs_n<=0, dc<=0,
//   lcd_data<=CMD_RAMWR, wr_n<=0. enable=0: stay.
//  CMD: one slot. At edge ending it: -> DATA; dc<=1, lcd_data<=rdata (=ram[0], rad has held 0
//   for >=2 cycles), rad<=1, wr_n<=0.
//  DATA: byte k loaded at slot start from rdata (ram[k]), with rad<=k+1 on the same edge, so
//   rdata is valid before next load (requires S>=2; S=1 illegal). Last byte
//   (k=FB_SIZE-1): rad<=0, never FB_SIZE (no out-of-range read).
//  End of last DATA slot: -> GAP; cs_n<=1, wr_n=1, dc<=1, frame_done<=1 for exactly one cycle.
//  GAP: GAP_CYC cycles, then -> IDLE; a new frame starts on the next edge if enable=1.
//  Frame period with enable held 1: 1 + (FB_SIZE+1)*S + GAP_CYC cycles.
//  enable deasserted mid-frame: current frame completes normally; stop in IDLE afterwards.
//  Byte counter is ceil(log2(FB_SIZE)) bits, wraps to 0 only via the last-byte rule above.
//  rdata sampled only on slot-start edges; ignored otherwise.
// TESTING (bench uses FB_SIZE=4, WR_LOW_CYC=2, WR_HIGH_CYC=2, GAP_CYC=3, RAM model 1-cycle latency)
//  1 RAM={11,22,33,44}, enable=1 -> LCD monitor sees 2C(dc=0),11,22,33,44(dc=1) on wr_n rises;
//    frame_done once; next frame starts after 1+5*4+3=24 cycles.
//  2 rad trace: 0 through CMD, then 1,2,3,0 at each DATA slot start; never reaches 4.
//  3 Drop enable during byte 2 -> bytes 33,44 still sent, frame_done pulses, FSM parks in IDLE,
//    cs_n=1, busy=0; re-raise enable -> new 2C starts next edge.
//  4 Assert reset mid-DATA (async, between edges) -> cs_n,wr_n,dc=1, data=0, rad=0 immediately;
//    after release with enable=1, frame restarts from command byte 2C.
//  5 Check per-byte timing: wr_n low exactly 2 cycles, high 2 cycles; lcd_data/dc change only on
//    slot-start edges; cs_n low from first CMD cycle to end of last DATA slot.

Source files
------------

// File: rtl/lcd_scanout.sv
// ============================================================================
// Module      : lcd_scanout
// Description : Streams the framebuffer RAM to an 8080-style 8-bit LCD,
//               a RAM-write command followed by every pixel byte, per frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_scanout #(
  parameter int unsigned FB_SIZE     = 153600,
  parameter int unsigned WR_LOW_CYC  = 2,
  parameter int unsigned WR_HIGH_CYC = 2,
  parameter int unsigned GAP_CYC     = 16,
  parameter logic [7:0]  CMD_RAMWR   = 8'h2C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [31:0] rad,
  input  logic [7:0]  rdata,
  output logic        lcd_cs_n,
  output logic        lcd_dc,
  output logic        lcd_wr_n,
  output logic [7:0]  lcd_data,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned c_SLOT = WR_LOW_CYC + WR_HIGH_CYC;
  localparam int unsigned c_PH_W = (c_SLOT > 1) ? $clog2(c_SLOT) : 1;
  localparam int unsigned c_BC_W = (FB_SIZE > 1) ? $clog2(FB_SIZE) : 1;
  localparam int unsigned c_GP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [c_PH_W-1:0] c_PH_LOW_END = c_PH_W'(WR_LOW_CYC - 1);
  localparam logic [c_PH_W-1:0] c_PH_LAST    = c_PH_W'(c_SLOT - 1);
  localparam logic [c_BC_W-1:0] c_BYTE_LAST  = c_BC_W'(FB_SIZE - 1);
  localparam logic [c_GP_W-1:0] c_GAP_LAST   = c_GP_W'(GAP_CYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]        r_state,  w_state_nxt;
  logic [c_PH_W-1:0] r_phase,  w_phase_nxt;
  logic [c_BC_W-1:0] r_byte,   w_byte_nxt;
  logic [c_GP_W-1:0] r_gap,    w_gap_nxt;
  logic [31:0]       r_rad,    w_rad_nxt;
  logic              r_cs_n,   w_cs_n_nxt;
  logic              r_dc,     w_dc_nxt;
  logic              r_wr_n,   w_wr_n_nxt;
  logic [7:0]        r_data,   w_data_nxt;
  logic              r_busy;
  logic              r_done,   w_done_nxt;

  logic              w_slot_end;
  logic              w_last_byte;
  logic [c_BC_W-1:0] w_next_k;
  logic [31:0]       w_next_rad;

  assign w_slot_end  = (r_phase == c_PH_LAST);
  assign w_last_byte = (r_byte == c_BYTE_LAST);
  assign w_next_k    = r_byte + c_BC_W'(1);
  // Prefetch address for the byte after k; the last byte points back to 0.
  assign w_next_rad  = (w_next_k == c_BYTE_LAST) ? 32'd0 : (32'(w_next_k) + 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_byte  <= '0;
      r_gap   <= '0;
      r_rad   <= 32'd0;
      r_cs_n  <= 1'b1;
      r_dc    <= 1'b1;
      r_wr_n  <= 1'b1;
      r_data  <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_byte  <= w_byte_nxt;
      r_gap   <= w_gap_nxt;
      r_rad   <= w_rad_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_dc    <= w_dc_nxt;
      r_wr_n  <= w_wr_n_nxt;
      r_data  <= w_data_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_state_nxt = S_CMD;
      S_CMD:   if (w_slot_end) w_state_nxt = S_DATA;
      S_DATA:  if (w_slot_end && w_last_byte) w_state_nxt = S_GAP;
      S_GAP:   if (r_gap == c_GAP_LAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_byte_nxt  = r_byte;
    w_gap_nxt   = r_gap;
    w_rad_nxt   = r_rad;
    w_cs_n_nxt  = r_cs_n;
    w_dc_nxt    = r_dc;
    w_wr_n_nxt  = r_wr_n;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_phase_nxt = '0;
        w_rad_nxt   = 32'd0;
        w_cs_n_nxt  = 1'b1;
        w_wr_n_nxt  = 1'b1;
        if (enable) begin
          w_cs_n_nxt = 1'b0;
          w_dc_nxt   = 1'b0;
          w_data_nxt = CMD_RAMWR;
          w_wr_n_nxt = 1'b0;
        end
      end
      S_CMD, S_DATA: begin
        w_phase_nxt = r_phase + c_PH_W'(1);
        if (r_phase == c_PH_LOW_END) w_wr_n_nxt = 1'b1;
        if (w_slot_end) begin
          w_phase_nxt = '0;
          if (r_state == S_CMD) begin
            w_dc_nxt   = 1'b1;
            w_data_nxt = rdata;
            w_byte_nxt = '0;
            w_rad_nxt  = (c_BYTE_LAST == '0) ? 32'd0 : 32'd1;
            w_wr_n_nxt = 1'b0;
          end else if (w_last_byte) begin
            w_cs_n_nxt = 1'b1;
            w_wr_n_nxt = 1'b1;
            w_dc_nxt   = 1'b1;
            w_done_nxt = 1'b1;
            w_byte_nxt = '0;
            w_rad_nxt  = 32'd0;
            w_gap_nxt  = '0;
          end else begin
            w_byte_nxt = w_next_k;
            w_data_nxt = rdata;
            w_rad_nxt  = w_next_rad;
            w_wr_n_nxt = 1'b0;
          end
        end
      end
      S_GAP: begin
        w_gap_nxt = (r_gap == c_GAP_LAST) ? '0 : r_gap + c_GP_W'(1);
      end
      default: ;
    endcase
  end

  assign rad        = r_rad;
  assign lcd_cs_n   = r_cs_n;
  assign lcd_dc     = r_dc;
  assign lcd_wr_n   = r_wr_n;
  assign lcd_data   = r_data;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

`default_nettype wire
